// File: rtl/page_pkg.sv
// page_pkg
// Shared definitions for the page display control path.
//   - page index constants for the three display pages
//   - default page count
//   - state encoding for the page-switch sequencer
// No ports; imported with "import page_pkg::*;".
package page_pkg;

  localparam int PAGE_PS2_DEBUG    = 0;
  localparam int PAGE_TEST_PIC     = 1;
  localparam int PAGE_DEBUG        = 2;
  localparam int NUM_PAGES_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } page_state_t;

endpackage

// File: rtl/page_switch_ctrl_debounce_edge.sv
// debounce_edge
// Cleans one asynchronous key level and reports its presses.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   raw   in  asynchronous key level, 1 = pressed
//   rise  out one-clk pulse on a debounced 0->1 transition
// The raw level passes a 2-flop synchroniser, then must hold a value
// different from the accepted level for DEBOUNCE_CYCLES consecutive
// samples before it is accepted.
module debounce_edge
  import page_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // Synchroniser, debounce counter and one-cycle-delayed copy of the
  // accepted level. Any sample agreeing with the accepted level restarts
  // the count, so only an unbroken run of differing samples gets through.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A held key keeps level high, so only the first cycle after acceptance
  // produces a pulse.
  assign rise = level & ~level_q;

endmodule

// File: rtl/page_switch_ctrl.sv
// page_switch_ctrl
// Turns key presses into a frame-aligned page select for the display muxes.
//   clk          in  system clock
//   rst          in  synchronous active-high reset
//   btn_next     in  raw matrix key, 1 = pressed (advance page)
//   key_space    in  PS/2 space level, 1 = held (advance page)
//   btn_prev     in  raw matrix key for page-back (PAGE_PREV_EN builds only)
//   v_sync       in  VGA vertical sync, active-low, asynchronous
//   page_status  out registered page select
//   blank        out 1 = downstream forces pixels to 0
//   page_changed out one-clk pulse on the cycle page_status updates
//   busy         out 1 while a switch is pending or blanking
// Optional feature macro: PAGE_PREV_EN adds the page-back key.
module page_switch_ctrl
  import page_pkg::*;
#(
  parameter int NUM_PAGES       = NUM_PAGES_DEFAULT,
  parameter int PAGE_W          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLANK_FRAMES    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              key_space,
  input  logic              btn_prev,
  input  logic              v_sync,
  output logic [PAGE_W-1:0] page_status,
  output logic              blank,
  output logic              page_changed,
  output logic              busy
);

  localparam logic [PAGE_W-1:0] LAST_PAGE  = PAGE_W'(NUM_PAGES - 1);
  localparam logic [PAGE_W-1:0] FIRST_PAGE = PAGE_W'(PAGE_PS2_DEBUG);
  localparam int BCNT_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLANK_FRAMES);

  logic next_rise;
  logic space_rise;
  logic fwd_req;
  logic back_req;

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_next),
    .rise (next_rise)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_space (
    .clk  (clk),
    .rst  (rst),
    .raw  (key_space),
    .rise (space_rise)
  );

`ifdef PAGE_PREV_EN
  logic prev_rise;

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_prev),
    .rise (prev_rise)
  );

  // Forward and backward presses landing together cancel out.
  assign fwd_req  = (next_rise | space_rise) & ~prev_rise;
  assign back_req = prev_rise & ~(next_rise | space_rise);
`else
  logic unused_btn_prev;

  assign unused_btn_prev = btn_prev;
  assign fwd_req         = next_rise | space_rise;
  assign back_req        = 1'b0;
`endif

  logic vs_sync1;
  logic vs_sync2;
  logic vs_prev;
  logic frame_start;

  // v_sync idles high, so its synchroniser resets to 1 to avoid reporting
  // a fake frame start straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_sync1 <= 1'b1;
      vs_sync2 <= 1'b1;
      vs_prev  <= 1'b1;
    end else begin
      vs_sync1 <= v_sync;
      vs_sync2 <= vs_sync1;
      vs_prev  <= vs_sync2;
    end
  end

  assign frame_start = vs_prev & ~vs_sync2;

  page_state_t       state_q, state_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic              blank_q, blank_d;
  logic              changed_q, changed_d;
  logic              dir_q, dir_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [BCNT_W-1:0] bcnt_inc;

  // Sequencer registers; every output is taken straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      page_q    <= FIRST_PAGE;
      blank_q   <= 1'b0;
      changed_q <= 1'b0;
      dir_q     <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      blank_q   <= blank_d;
      changed_q <= changed_d;
      dir_q     <= dir_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign bcnt_inc = bcnt_q + 1'b1;

  // Next-state logic. A request only arms the switch; the page itself
  // moves on the following frame start, so a request arriving together
  // with a frame start waits for the next one. Requests seen outside IDLE
  // are dropped rather than queued. dir_q = 1 means step backwards.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    blank_d   = blank_q;
    changed_d = 1'b0;
    dir_d     = dir_q;
    bcnt_d    = bcnt_q;
    case (state_q)
      IDLE: begin
        if (fwd_req) begin
          state_d = PENDING;
          dir_d   = 1'b0;
        end else if (back_req) begin
          state_d = PENDING;
          dir_d   = 1'b1;
        end
      end
      PENDING: begin
        if (frame_start) begin
          if (dir_q) begin
            page_d = (page_q == '0) ? LAST_PAGE : page_q - 1'b1;
          end else begin
            page_d = (page_q == LAST_PAGE) ? '0 : page_q + 1'b1;
          end
          changed_d = 1'b1;
          if (BLANK_FRAMES > 0) begin
            blank_d = 1'b1;
            bcnt_d  = '0;
            state_d = BLANK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BLANK: begin
        if (frame_start) begin
          bcnt_d = bcnt_inc;
          if (bcnt_inc == BCNT_LAST) begin
            blank_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign page_status  = page_q;
  assign blank        = blank_q;
  assign page_changed = changed_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_page_switch_ctrl.sv
// tb_page_switch_ctrl
// Directed bench for page_switch_ctrl with a short debounce (4 clk) and one
// blanking frame. Frames are 200 clk long; v_sync is driven from the main
// sequence so every frame start lands on a known cycle.
module tb_page_switch_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_next;
  logic       key_space;
  logic       btn_prev;
  logic       v_sync;
  logic [1:0] page_status;
  logic       blank;
  logic       page_changed;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int pc_count = 0;

  page_switch_ctrl #(
    .NUM_PAGES       (3),
    .PAGE_W          (2),
    .DEBOUNCE_CYCLES (4),
    .BLANK_FRAMES    (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_next     (btn_next),
    .key_space    (key_space),
    .btn_prev     (btn_prev),
    .v_sync       (v_sync),
    .page_status  (page_status),
    .blank        (blank),
    .page_changed (page_changed),
    .busy         (busy)
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally page_changed pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (page_changed === 1'b1) pc_count++;
  end

  // Step one clock, leaving 1 ns after the edge for driving and sampling.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One comparison point.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Clean press of the selected keys for 10 clk, then release and settle.
  task automatic apply_stimulus(input logic nxt, input logic spc, input logic prv);
    btn_next  = nxt;
    key_space = spc;
    btn_prev  = prv;
    tick(10);
    btn_next  = 1'b0;
    key_space = 1'b0;
    btn_prev  = 1'b0;
    tick(10);
  endtask

  // Drop v_sync and stop 2 clk later: the synchronised frame-start pulse
  // is active in this cycle, so the page must still be unchanged.
  task automatic frame_fall();
    v_sync = 1'b0;
    tick(2);
  endtask

  // Remainder of a 200 clk frame after frame_fall plus one more tick.
  task automatic frame_tail();
    tick(7);
    v_sync = 1'b1;
    tick(190);
  endtask

  // Main directed sequence.
  initial begin
    rst       = 1'b1;
    btn_next  = 1'b0;
    key_space = 1'b0;
    btn_prev  = 1'b0;
    v_sync    = 1'b1;
    tick(3);
    rst = 1'b0;
    check_output("rst_page", 32'(page_status), 32'd0);
    check_output("rst_blank", 32'(blank), 32'd0);
    check_output("rst_changed", 32'(page_changed), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);

    $display("[TB] clean press of btn_next");
    btn_next = 1'b1;
    tick(10);
    check_output("t1_busy_armed", 32'(busy), 32'd1);
    check_output("t1_page_held", 32'(page_status), 32'd0);
    btn_next = 1'b0;
    tick(10);
    frame_fall();
    check_output("t1_page_before_edge", 32'(page_status), 32'd0);
    tick(1);
    check_output("t1_page_switched", 32'(page_status), 32'd1);
    check_output("t1_changed_pulse", 32'(page_changed), 32'd1);
    check_output("t1_blank_on", 32'(blank), 32'd1);
    check_output("t1_busy_blank", 32'(busy), 32'd1);
    tick(1);
    check_output("t1_changed_one_clk", 32'(page_changed), 32'd0);
    check_output("t1_blank_held", 32'(blank), 32'd1);
    tick(6);
    v_sync = 1'b1;
    tick(190);
    frame_fall();
    tick(1);
    check_output("t1_blank_off", 32'(blank), 32'd0);
    check_output("t1_busy_off", 32'(busy), 32'd0);
    check_output("t1_page_kept", 32'(page_status), 32'd1);
    frame_tail();
    check_output("t1_pulse_count", 32'(pc_count), 32'd1);

    $display("[TB] bouncing btn_next");
    for (int i = 0; i < 2; i++) begin
      btn_next = 1'b1;
      tick(2);
      btn_next = 1'b0;
      tick(2);
    end
    tick(6);
    check_output("t2_bounce_ignored", 32'(busy), 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("t2_busy_armed", 32'(busy), 32'd1);
    frame_fall();
    tick(1);
    check_output("t2_page_plus1", 32'(page_status), 32'd2);
    frame_tail();
    frame_fall();
    tick(1);
    frame_tail();
    check_output("t2_idle", 32'(busy), 32'd0);
    check_output("t2_pulse_count", 32'(pc_count), 32'd2);

    $display("[TB] wrap from last page");
    apply_stimulus(1'b1, 1'b0, 1'b0);
    frame_fall();
    tick(1);
    check_output("t3_wrap_page", 32'(page_status), 32'd0);
    check_output("t3_wrap_changed", 32'(page_changed), 32'd1);
    frame_tail();
    frame_fall();
    tick(1);
    frame_tail();
    check_output("t3_idle", 32'(busy), 32'd0);

    $display("[TB] simultaneous keys plus press during pending");
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("t4_busy_armed", 32'(busy), 32'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    frame_fall();
    tick(1);
    check_output("t4_single_advance", 32'(page_status), 32'd1);
    frame_tail();
    frame_fall();
    tick(1);
    frame_tail();
    frame_fall();
    tick(1);
    check_output("t4_no_queued_req", 32'(page_status), 32'd1);
    check_output("t4_no_queued_busy", 32'(busy), 32'd0);
    frame_tail();
    check_output("t4_pulse_count", 32'(pc_count), 32'd4);

    $display("[TB] reset during blanking");
    apply_stimulus(1'b1, 1'b0, 1'b0);
    frame_fall();
    tick(1);
    check_output("t5_page_two", 32'(page_status), 32'd2);
    check_output("t5_in_blank", 32'(blank), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_output("t5_rst_page", 32'(page_status), 32'd0);
    check_output("t5_rst_blank", 32'(blank), 32'd0);
    check_output("t5_rst_busy", 32'(busy), 32'd0);
    check_output("t5_rst_changed", 32'(page_changed), 32'd0);
    tick(1);
    check_output("t5_stays_reset", 32'(page_status), 32'd0);
    frame_tail();
    frame_fall();
    tick(1);
    check_output("t5_no_phantom_page", 32'(page_status), 32'd0);
    check_output("t5_no_phantom_busy", 32'(busy), 32'd0);
    frame_tail();

`ifdef PAGE_PREV_EN
    $display("[TB] page-back key");
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("t6_prev_armed", 32'(busy), 32'd1);
    frame_fall();
    tick(1);
    check_output("t6_prev_wrap", 32'(page_status), 32'd2);
    frame_tail();
    frame_fall();
    tick(1);
    frame_tail();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("t6_cancel_busy", 32'(busy), 32'd0);
    frame_fall();
    tick(1);
    check_output("t6_cancel_page", 32'(page_status), 32'd0);
    frame_tail();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/page_switch_ctrl.md
Name: page_switch_ctrl

Overview:
Upstream stage of the page display top level. Converts raw button and PS/2 key levels into the registered page_status select that drives the pixel-data and button-routing muxes. Each input is synchronised and debounced, then reduced to a single page-advance request. The page change is applied only at a frame boundary, followed by an optional blanking window so no frame is torn.

Parameters:
NUM_PAGES, 3, number of selectable pages; page_status wraps NUM_PAGES-1 -> 0
PAGE_W, 2, width of page_status; NUM_PAGES must be <= 2**PAGE_W
DEBOUNCE_CYCLES, 1000000, consecutive identical clk samples needed to accept a new level (10 ms at 100 MHz)
BLANK_FRAMES, 1, frames during which blank is held high after a switch; 0 disables blanking

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
btn_next  in  1  raw matrix-key level, async, 1 = pressed
key_space  in  1  PS/2 space level, async, 1 = held
btn_prev  in  1  raw matrix-key level for page-back; used only with PAGE_PREV_EN
v_sync  in  1  VGA vertical sync, active-low, async to clk
page_status  out  PAGE_W  registered page select
blank  out  1  1 = downstream mux forces pixel output to 0
page_changed  out  1  one-clk pulse on the cycle page_status updates
busy  out  1  1 while in PENDING or BLANK

Behaviour:
- Reset (rst=1 at a clk edge): page_status=0, blank=0, page_changed=0, busy=0, state=IDLE. Debounced levels clear to 0, debounce counters clear, synchroniser flops clear to 0 (v_sync flops clear to 1).
- Synchronise every async input with 2 flops.
- Debounce: the debounced level takes the new sample after DEBOUNCE_CYCLES consecutive samples that differ from the current debounced level. Any sample equal to the current level resets the counter.
- Edge detect: a debounced 0->1 transition produces a 1-cycle req pulse. A next_req is the OR of the btn_next and key_space edges, so simultaneous edges count as one request.
- Frame start: the synchronised v_sync 1->0 transition, one pulse per frame.
- FSM IDLE:
  - next_req -> PENDING, dir=+1, busy=1.
- FSM PENDING:
  - All new requests are ignored (no queueing).
  - On frame start: page_status <= (page_status==NUM_PAGES-1) ? 0 : page_status+1, and page_changed=1 for that cycle.
  - If BLANK_FRAMES>0: blank=1 and the state goes to BLANK with frame count=0. Otherwise the state goes to IDLE.
- FSM BLANK:
  - Each frame start increments the count.
  - When the count reaches BLANK_FRAMES: blank=0, busy=0, state goes to IDLE, all on the same cycle.
  - Requests are ignored.
- Latency: a request is applied 1 to 2 frames after the debounced edge. page_status changes exactly on the clk cycle after the frame-start pulse.
- If a req and a frame start arrive on the same cycle in IDLE, the FSM goes to PENDING only. The page does not change until the next frame start.
- Reset in PENDING or BLANK aborts the switch immediately: page_status=0 and blank=0.
- A held button produces exactly one request; the next request needs a release followed by a new press.

Optional Feature:
PAGE_PREV_EN
- Defined: btn_prev is debounced and edge-detected like btn_next. Its edge gives prev_req, which moves the FSM to PENDING with dir=-1, and the page wraps 0 -> NUM_PAGES-1.
- A next_req and prev_req on the same cycle cancel: no request.
- Undefined: the btn_prev synchroniser and debouncer are not built, and the input is ignored.

Decomposition:
- Shared package page_pkg holds:
  - page index constants: PAGE_PS2_DEBUG=0, PAGE_TEST_PIC=1, PAGE_DEBUG=2
  - NUM_PAGES_DEFAULT=3
  - FSM state encoding: IDLE, PENDING, BLANK
- One natural sub-module, debounce_edge: synchroniser, debounce counter and rising-edge pulse. It is instantiated once per input: two instances, three with PAGE_PREV_EN.

Test Plan:
1. DEBOUNCE_CYCLES=4, BLANK_FRAMES=1. Press btn_next cleanly, with frame start every 200 clk. Required: page_status 0->1 on the cycle after the next frame start; page_changed pulses once; blank=1 for one frame.
2. Bounce btn_next 1-0-1-0 at 2-clk spacing, then hold for 10 clk. Required: exactly one request, page advances by exactly 1.
3. Start at page 2, press btn_next. Required: page_status wraps to 0.
4. Raise btn_next and key_space on the same clk, and press again during PENDING. Required: a single advance 0->1; the second press is ignored.
5. Assert rst for 1 clk while in BLANK with page_status=2. Required: the next cycle shows page_status=0, blank=0, busy=0; no page_changed pulse.
6. With PAGE_PREV_EN, starting at page 0:
   - btn_prev alone gives page_status=2.
   - btn_prev and btn_next on the same cycle give no change and busy stays 0.
